// File: rtl/bist_pattern_compactor.sv
// BIST engine: Galois LFSR drives the circuit under test, a Galois MISR compacts its
// (optionally delayed) responses, and the final signature is compared to a golden value.
module bist_pattern_compactor #(
  parameter int unsigned          IN_WIDTH   = 15,
  parameter int unsigned          OUT_WIDTH  = 14,
  parameter int unsigned          TEST_COUNT = 148,
  parameter int unsigned          RESP_LAT   = 0,
  parameter logic [IN_WIDTH-1:0]  LFSR_POLY  = 15'h0003,
  parameter logic [OUT_WIDTH-1:0] MISR_POLY  = 14'h002B
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [IN_WIDTH-1:0]                seed_in,
  input  logic [OUT_WIDTH-1:0]               golden_sig,
  input  logic [OUT_WIDTH-1:0]               cut_response,
  output logic [IN_WIDTH-1:0]                test_vector,
  output logic                               vector_valid,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic [OUT_WIDTH-1:0]               signature,
  output logic [$clog2(TEST_COUNT+1)-1:0]    vec_count
);

  localparam int unsigned     CntW      = $clog2(TEST_COUNT + 1);
  localparam logic [CntW-1:0] LastCnt   = CntW'(TEST_COUNT - 1);
  localparam logic [1:0]      DrainLast = 2'(RESP_LAT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [IN_WIDTH-1:0]   lfsr_q, lfsr_d, lfsr_step;
  logic [OUT_WIDTH-1:0]  misr_q, misr_d, misr_step;
  logic [OUT_WIDTH-1:0]  golden_q, golden_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [1:0]            drain_q, drain_d;
  logic                  vv_q, vv_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  resp_valid;

  // Response qualifier: vector_valid delayed by RESP_LAT cycles.
  generate
    if (RESP_LAT == 0) begin : g_no_lat
      assign resp_valid = vv_q;
    end else begin : g_lat
      logic [RESP_LAT-1:0] pipe_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          pipe_q <= '0;
        end else begin
          pipe_q[0] <= vv_q;
          for (int i = 1; i < RESP_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end
      assign resp_valid = pipe_q[RESP_LAT-1];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    misr_d    = misr_q;
    golden_d  = golden_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    lfsr_step = {lfsr_q[IN_WIDTH-2:0], 1'b0} ^ (lfsr_q[IN_WIDTH-1] ? LFSR_POLY : '0);
    misr_step = {misr_q[OUT_WIDTH-2:0], 1'b0} ^ (misr_q[OUT_WIDTH-1] ? MISR_POLY : '0);

    if (resp_valid) begin
      misr_d = misr_step ^ cut_response;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StRun;
          // An all-zero seed would lock the LFSR up.
          lfsr_d   = (seed_in == '0) ? {{(IN_WIDTH-1){1'b0}}, 1'b1} : seed_in;
          misr_d   = '0;
          golden_d = golden_sig;
          cnt_d    = '0;
          drain_d  = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = (RESP_LAT > 0) ? StDrain : StDone;
        end else begin
          lfsr_d = lfsr_step;
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    vv_d   = (state_d == StRun);
    busy_d = (state_d == StRun) || (state_d == StDrain);
    done_d = (state_d == StDone);
    pass_d = (state_d == StDone) && (misr_d == golden_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      lfsr_q   <= '0;
      misr_q   <= '0;
      golden_q <= '0;
      cnt_q    <= '0;
      drain_q  <= '0;
      vv_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      misr_q   <= misr_d;
      golden_q <= golden_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      vv_q     <= vv_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign test_vector  = lfsr_q;
  assign vector_valid = vv_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign signature    = misr_q;
  assign vec_count    = cnt_q;

endmodule

// File: tb/tb_bist_pattern_compactor.sv
// Directed bench for bist_pattern_compactor: small 4-bit instances with hand-derived
// LFSR sequences, MISR signatures and done timing.
module tb_bist_pattern_compactor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] exp_seq [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                               4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};

  // Instance A: sequence, zero seed, reset and start handling.
  logic       a_reset = 1'b1, a_start = 1'b0;
  logic [3:0] a_seed = '0, a_golden = '0, a_resp = '0;
  logic [3:0] a_tv, a_sig;
  logic       a_vv, a_busy, a_done, a_pass;
  logic [4:0] a_cnt;

  bist_pattern_compactor #(
    .IN_WIDTH(4), .OUT_WIDTH(4), .TEST_COUNT(16), .RESP_LAT(0),
    .LFSR_POLY(4'h3), .MISR_POLY(4'h3)
  ) u_a (
    .clk(clk), .reset(a_reset), .start(a_start), .seed_in(a_seed), .golden_sig(a_golden),
    .cut_response(a_resp), .test_vector(a_tv), .vector_valid(a_vv), .busy(a_busy),
    .done(a_done), .pass(a_pass), .signature(a_sig), .vec_count(a_cnt)
  );

  // Instance M: MISR arithmetic over two vectors.
  logic       m_reset = 1'b1, m_start = 1'b0;
  logic [3:0] m_seed = 4'h1, m_golden = '0, m_resp = 4'h1;
  logic [3:0] m_tv, m_sig;
  logic       m_vv, m_busy, m_done, m_pass;
  logic [1:0] m_cnt;

  bist_pattern_compactor #(
    .IN_WIDTH(4), .OUT_WIDTH(4), .TEST_COUNT(2), .RESP_LAT(0),
    .LFSR_POLY(4'h3), .MISR_POLY(4'h3)
  ) u_m (
    .clk(clk), .reset(m_reset), .start(m_start), .seed_in(m_seed), .golden_sig(m_golden),
    .cut_response(m_resp), .test_vector(m_tv), .vector_valid(m_vv), .busy(m_busy),
    .done(m_done), .pass(m_pass), .signature(m_sig), .vec_count(m_cnt)
  );

  // Instances L0/L2: same run with no latency and with a two-cycle response delay.
  logic       l_reset = 1'b1, l_start = 1'b0;
  logic [3:0] l_seed = '0, l_golden = '0;
  logic [3:0] l0_tv, l0_sig, l2_tv, l2_sig, l2_d1, l2_d2;
  logic       l0_vv, l0_busy, l0_done, l0_pass, l2_vv, l2_busy, l2_done, l2_pass;
  logic [4:0] l0_cnt, l2_cnt;

  always @(posedge clk) begin
    l2_d1 <= l2_tv;
    l2_d2 <= l2_d1;
  end

  bist_pattern_compactor #(
    .IN_WIDTH(4), .OUT_WIDTH(4), .TEST_COUNT(16), .RESP_LAT(0),
    .LFSR_POLY(4'h3), .MISR_POLY(4'h9)
  ) u_l0 (
    .clk(clk), .reset(l_reset), .start(l_start), .seed_in(l_seed), .golden_sig(l_golden),
    .cut_response(l0_tv), .test_vector(l0_tv), .vector_valid(l0_vv), .busy(l0_busy),
    .done(l0_done), .pass(l0_pass), .signature(l0_sig), .vec_count(l0_cnt)
  );

  bist_pattern_compactor #(
    .IN_WIDTH(4), .OUT_WIDTH(4), .TEST_COUNT(16), .RESP_LAT(2),
    .LFSR_POLY(4'h3), .MISR_POLY(4'h9)
  ) u_l2 (
    .clk(clk), .reset(l_reset), .start(l_start), .seed_in(l_seed), .golden_sig(l_golden),
    .cut_response(l2_d2), .test_vector(l2_tv), .vector_valid(l2_vv), .busy(l2_busy),
    .done(l2_done), .pass(l2_pass), .signature(l2_sig), .vec_count(l2_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_reset = 1'b1; m_reset = 1'b1; l_reset = 1'b1;
    tick();
    tick();
    a_reset = 1'b0; m_reset = 1'b0; l_reset = 1'b0;
    vectors++;
    if ({a_tv, a_sig, a_cnt} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_a_data: got tv=%h sig=%h cnt=%0d, expected all 0", a_tv, a_sig, a_cnt);
    end
    vectors++;
    if ({a_vv, a_busy, a_done, a_pass} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_a_flags: got vv/busy/done/pass=%b, expected 0000",
               {a_vv, a_busy, a_done, a_pass});
    end
    vectors++;
    if ({m_tv, m_sig, m_cnt, m_vv, m_busy, m_done, m_pass} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_m: got tv=%h sig=%h cnt=%0d flags=%b, expected all 0",
               m_tv, m_sig, m_cnt, {m_vv, m_busy, m_done, m_pass});
    end
  endtask

  // Starts instance A with the given seed and checks the full 16-vector sequence.
  task automatic run_a_sequence(input string name, input logic [3:0] seed);
    a_seed = seed; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (a_tv !== exp_seq[k] || a_tv === 4'h0 || a_cnt !== 5'(k) ||
          {a_vv, a_busy, a_done} !== 3'b110) begin
        miscompares++;
        $display("FAIL %s_vec[%0d]: got tv=%h cnt=%0d vv/busy/done=%b, expected tv=%h cnt=%0d 110",
                 name, k, a_tv, a_cnt, {a_vv, a_busy, a_done}, exp_seq[k], k);
      end
      tick();
    end
    vectors++;
    if ({a_vv, a_busy, a_done} !== 3'b001 || a_cnt !== 5'd16 || a_tv !== 4'h1) begin
      miscompares++;
      $display("FAIL %s_done: got vv/busy/done=%b cnt=%0d tv=%h, expected 001 cnt=16 tv=1",
               name, {a_vv, a_busy, a_done}, a_cnt, a_tv);
    end
  endtask

  task automatic test_lfsr_sequence();
    a_resp = 4'h0; a_golden = 4'h0;
    run_a_sequence("lfsr", 4'h1);
    vectors++;
    if (a_sig !== 4'h0 || a_pass !== 1'b1) begin
      miscompares++;
      $display("FAIL lfsr_pass: got sig=%h pass=%b, expected sig=0 pass=1", a_sig, a_pass);
    end
  endtask

  task automatic test_zero_seed();
    run_a_sequence("zero_seed", 4'h0);
  endtask

  task automatic test_misr_arith();
    m_resp = 4'h1; m_golden = 4'h3; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    tick();
    tick();
    vectors++;
    if (m_done !== 1'b1 || m_sig !== 4'h3 || m_pass !== 1'b1) begin
      miscompares++;
      $display("FAIL misr_pass: got done=%b sig=%h pass=%b, expected done=1 sig=3 pass=1",
               m_done, m_sig, m_pass);
    end
    // Restart straight from DONE with a wrong golden value.
    m_golden = 4'h2; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    vectors++;
    if ({m_busy, m_done, m_pass} !== 3'b100 || m_sig !== 4'h0 || m_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL misr_restart: got busy/done/pass=%b sig=%h cnt=%0d, expected 100 sig=0 cnt=0",
               {m_busy, m_done, m_pass}, m_sig, m_cnt);
    end
    tick();
    tick();
    vectors++;
    if (m_done !== 1'b1 || m_sig !== 4'h3 || m_pass !== 1'b0) begin
      miscompares++;
      $display("FAIL misr_fail: got done=%b sig=%h pass=%b, expected done=1 sig=3 pass=0",
               m_done, m_sig, m_pass);
    end
  endtask

  task automatic test_latency();
    int t0 = -1;
    int t2 = -1;
    l_seed = 4'h1; l_golden = 4'h1; l_start = 1'b1;
    tick();
    l_start = 1'b0;
    for (int t = 1; t <= 40 && t2 < 0; t++) begin
      tick();
      if (l0_done === 1'b1 && t0 < 0) t0 = t;
      if (l2_done === 1'b1 && t2 < 0) t2 = t;
    end
    vectors++;
    if (t0 !== 16) begin
      miscompares++;
      $display("FAIL lat0_done_time: got %0d cycles, expected 16", t0);
    end
    vectors++;
    if (t2 !== 18) begin
      miscompares++;
      $display("FAIL lat2_done_time: got %0d cycles, expected 18", t2);
    end
    vectors++;
    if (l0_sig !== 4'h1 || l0_pass !== 1'b1) begin
      miscompares++;
      $display("FAIL lat0_sig: got sig=%h pass=%b, expected sig=1 pass=1", l0_sig, l0_pass);
    end
    vectors++;
    if (l2_sig !== 4'h1 || l2_pass !== 1'b1 || l2_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL lat2_sig: got sig=%h pass=%b busy=%b, expected sig=1 pass=1 busy=0",
               l2_sig, l2_pass, l2_busy);
    end
  endtask

  task automatic test_reset_midrun();
    a_resp = 4'h0; a_seed = 4'h1; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 10 && a_cnt !== 5'd5; i++) tick();
    vectors++;
    if (a_cnt !== 5'd5 || a_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_reach: got cnt=%0d busy=%b, expected cnt=5 busy=1", a_cnt, a_busy);
    end
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    vectors++;
    if ({a_tv, a_sig, a_cnt, a_vv, a_busy, a_done, a_pass} !== 17'd0) begin
      miscompares++;
      $display("FAIL midrun_reset: got tv=%h sig=%h cnt=%0d flags=%b, expected all 0",
               a_tv, a_sig, a_cnt, {a_vv, a_busy, a_done, a_pass});
    end
    tick();
    vectors++;
    if ({a_vv, a_busy, a_done, a_cnt} !== 8'd0) begin
      miscompares++;
      $display("FAIL midrun_idle: got flags=%b cnt=%0d, expected idle with zeros",
               {a_vv, a_busy, a_done}, a_cnt);
    end
    run_a_sequence("after_reset", 4'h1);
  endtask

  task automatic test_start_handling();
    a_resp = 4'h5; a_golden = 4'h5; a_seed = 4'h1; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    tick();
    tick();
    // Stray start mid-run with different seed and golden must be ignored.
    a_seed = 4'h7; a_golden = 4'h0; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    vectors++;
    if (a_cnt !== 5'd4 || a_tv !== 4'h3 || a_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_in_run: got cnt=%0d tv=%h busy=%b, expected cnt=4 tv=3 busy=1",
               a_cnt, a_tv, a_busy);
    end
    for (int i = 0; i < 12; i++) tick();
    vectors++;
    if (a_done !== 1'b1 || a_cnt !== 5'd16 || a_sig !== 4'h5 || a_pass !== 1'b1) begin
      miscompares++;
      $display("FAIL start_run_done: got done=%b cnt=%0d sig=%h pass=%b, expected 1 16 5 1",
               a_done, a_cnt, a_sig, a_pass);
    end
    a_seed = 4'h1; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    vectors++;
    if ({a_vv, a_busy, a_done, a_pass} !== 4'b1100 || a_sig !== 4'h0 || a_cnt !== 5'd0 ||
        a_tv !== 4'h1) begin
      miscompares++;
      $display("FAIL start_in_done: got flags=%b sig=%h cnt=%0d tv=%h, expected 1100 0 0 1",
               {a_vv, a_busy, a_done, a_pass}, a_sig, a_cnt, a_tv);
    end
  endtask

  initial begin
    test_reset();
    test_lfsr_sequence();
    test_zero_seed();
    test_misr_arith();
    test_latency();
    test_reset_midrun();
    test_start_handling();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
